// File: rtl/inst_issue_unit.sv
// Instruction issue unit.
// A small program buffer is loaded while idle. A run issues the words one at a
// time to the datapath with a valid/ready handshake. The run can single-step,
// be aborted, and stops at a zero (halt) word or after the last buffer entry.
//
// state | meaning
// IDLE  | waiting for start; buffer writes accepted
// ISSUE | presenting buf[pc] to the datapath
// PAUSE | step mode: waiting for a step pulse
// DONE  | one-cycle end-of-run pulse
module inst_issue_unit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_we,
    input  logic [$clog2(DEPTH)-1:0]  load_addr,
    input  logic [DATA_W-1:0]         load_data,
    input  logic                      start,
    input  logic                      step_mode,
    input  logic                      step,
    input  logic                      abort,
    input  logic                      inst_ready,
    output logic [DATA_W-1:0]         inst_ex,
    output logic                      inst_valid,
    output logic [$clog2(DEPTH)-1:0]  pc,
    output logic [$clog2(DEPTH):0]    issue_count,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [DATA_W-1:0]  cur_word;
    logic               halt;
    logic               xfer;
    logic               last;
    logic               mem_we;

    assign cur_word = mem_q[pc_q];
    assign halt     = (cur_word == '0);
    assign last     = (pc_q == PC_LAST);
    assign mem_we   = (state_q == IDLE) && load_we;

    // Outputs are gated by rst so they drop immediately, without waiting for a clock.
    assign inst_valid  = !rst && (state_q == ISSUE) && !halt;
    assign inst_ex     = inst_valid ? cur_word : '0;
    assign busy        = !rst && ((state_q == ISSUE) || (state_q == PAUSE));
    assign done        = !rst && (state_q == DONE);
    assign pc          = pc_q;
    assign issue_count = cnt_q;
    assign xfer        = inst_valid && inst_ready;

    // Program buffer: written only while idle, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // State, program counter and transfer counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a transfer is counted even when abort picks the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!last) begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (halt) begin
                    state_d = DONE;
                end else if (xfer) begin
                    if (last) begin
                        state_d = DONE;
                    end else if (step_mode) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (step) begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_issue_unit.sv
// Testbench for inst_issue_unit: directed scenarios plus random traffic,
// all compared against a program-level reference model.
module tb_inst_issue_unit;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_we;
    logic [AW-1:0]   load_addr;
    logic [DW-1:0]   load_data;
    logic            start;
    logic            step_mode;
    logic            step;
    logic            abort;
    logic            inst_ready;
    logic [DW-1:0]   inst_ex;
    logic            inst_valid;
    logic [AW-1:0]   pc;
    logic [AW:0]     issue_count;
    logic            busy;
    logic            done;

    inst_issue_unit #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .start(start), .step_mode(step_mode), .step(step), .abort(abort),
        .inst_ready(inst_ready),
        .inst_ex(inst_ex), .inst_valid(inst_valid), .pc(pc),
        .issue_count(issue_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: program memory plus run status.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_END = 3;
    logic [DW-1:0] m_mem [DEPTH];
    int            m_st;
    int            m_pc;
    int            m_cnt;
    logic [DW-1:0] issued_q [$];
    int            done_seen;

    function automatic bit m_valid();
        return (m_st == M_RUN) && (m_mem[m_pc] != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_st  = M_IDLE;
        m_pc  = 0;
        m_cnt = 0;
    endtask

    task automatic clear_inputs();
        load_we = 0; load_addr = '0; load_data = '0; start = 0;
        step = 0; abort = 0;
    endtask

    // Compare all outputs against the model, take one clock, advance the model.
    task automatic tick();
        bit v, x;
        v = m_valid();
        chk("inst_valid", inst_valid, v);
        chk("inst_ex", inst_ex, v ? m_mem[m_pc] : 0);
        chk("pc", pc, m_pc);
        chk("issue_count", issue_count, m_cnt);
        chk("busy", busy, (m_st == M_RUN) || (m_st == M_PAUSE));
        chk("done", done, m_st == M_END);
        if (done) done_seen++;
        @(posedge clk);
        x = v && inst_ready;
        case (m_st)
            M_IDLE: begin
                if (load_we) m_mem[load_addr] = load_data;
                if (start) begin m_st = M_RUN; m_pc = 0; m_cnt = 0; end
            end
            M_RUN: begin
                int old_pc;
                old_pc = m_pc;
                if (x) begin
                    issued_q.push_back(m_mem[m_pc]);
                    m_cnt++;
                    if (m_pc < DEPTH - 1) m_pc++;
                end
                if (abort) m_st = M_IDLE;
                else if (!v) m_st = M_END;
                else if (x) m_st = (old_pc == DEPTH - 1) ? M_END : (step_mode ? M_PAUSE : M_RUN);
            end
            M_PAUSE: begin
                if (abort) m_st = M_IDLE;
                else if (step) m_st = M_RUN;
            end
            default: m_st = M_IDLE;
        endcase
        #1;
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        clear_inputs();
        load_we = 1; load_addr = AW'(a); load_data = d;
        tick();
        load_we = 0;
    endtask

    task automatic load_prog3();
        load(0, 32'h54010005);
        load(1, 32'h50060002);
        load(2, 32'h0);
    endtask

    task automatic begin_run();
        clear_inputs();
        issued_q.delete();
        done_seen = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    // Run until the model returns to idle, bounded.
    task automatic run_to_idle(input string tag);
        int n;
        n = 0;
        while (m_st != M_IDLE && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, n < 100, 1);
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        step_mode = 0;
        inst_ready = 0;
        model_reset();
        done_seen = 0;
        #12;
        chk("rst_valid", inst_valid, 0);
        chk("rst_ex", inst_ex, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", issue_count, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Basic program, always ready.
        load_prog3();
        inst_ready = 1;
        begin_run();
        run_to_idle("r41");
        chk("r41_n", issued_q.size(), 2);
        if (issued_q.size() == 2) begin
            chk("r41_i0", issued_q[0], 32'h54010005);
            chk("r41_i1", issued_q[1], 32'h50060002);
        end
        chk("r41_done", done_seen, 1);
        chk("r41_cnt", issue_count, 2);

        // Back-pressure for three cycles.
        inst_ready = 0;
        begin_run();
        for (int i = 0; i < 3; i++) begin
            chk("r42_hold_ex", inst_ex, 32'h54010005);
            chk("r42_hold_pc", pc, 0);
            tick();
        end
        inst_ready = 1;
        run_to_idle("r42");
        chk("r42_n", issued_q.size(), 2);

        // Step mode with extra step pulses while issuing.
        step_mode = 1;
        inst_ready = 1;
        begin_run();
        tick();
        chk("r43_pause_valid", inst_valid, 0);
        chk("r43_pause_busy", busy, 1);
        tick();
        step = 1; tick(); step = 0;
        inst_ready = 0;
        step = 1; tick(); tick(); step = 0;
        chk("r43_ex", inst_ex, 32'h50060002);
        inst_ready = 1;
        tick();
        step = 1; tick(); step = 0;
        run_to_idle("r43");
        chk("r43_n", issued_q.size(), 2);
        chk("r43_done", done_seen, 1);
        step_mode = 0;

        // Full buffer of non-zero words.
        for (int i = 0; i < DEPTH; i++) load(i, 32'h1000_0000 + i * 3 + 1);
        begin_run();
        run_to_idle("r44");
        chk("r44_n", issued_q.size(), 8);
        if (issued_q.size() == 8) chk("r44_last", issued_q[7], 32'h1000_0016);
        chk("r44_pc", pc, 7);
        chk("r44_cnt", issue_count, 8);
        chk("r44_done", done_seen, 1);

        // Abort on the second transfer; a load during ISSUE is ignored.
        load_prog3();
        load(2, 32'h12345678);
        begin_run();
        tick();
        abort = 1; load_we = 1; load_addr = 0; load_data = 32'hDEADBEEF;
        tick();
        clear_inputs();
        chk("r45_cnt", issue_count, 2);
        chk("r45_busy", busy, 0);
        tick(); tick();
        chk("r45_done", done_seen, 0);
        inst_ready = 0;
        begin_run();
        chk("r45_mem0", inst_ex, 32'h54010005);
        abort = 1; tick(); abort = 0;

        // Asynchronous reset mid-run.
        begin_run();
        tick();
        chk("r46_pre_valid", inst_valid, 1);
        #2 rst = 1;
        #1;
        chk("r46_valid", inst_valid, 0);
        chk("r46_ex", inst_ex, 0);
        chk("r46_busy", busy, 0);
        chk("r46_pc", pc, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        inst_ready = 1;
        begin_run();
        tick();
        chk("r46_halt_done", done, 1);
        run_to_idle("r46");
        chk("r46_n", issued_q.size(), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            load_we    = ($urandom % 4) == 0;
            load_addr  = AW'($urandom % DEPTH);
            load_data  = (($urandom % 4) == 0) ? 32'h0 : $urandom;
            start      = ($urandom % 6) == 0;
            step_mode  = ($urandom % 3) == 0;
            step       = ($urandom % 3) == 0;
            abort      = ($urandom % 40) == 0;
            inst_ready = ($urandom % 4) != 0;
            tick();
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_issue_unit.md
INST_ISSUE_UNIT -- requirements
Module: inst_issue_unit

Interface
REQ-001 Parameter DEPTH, default 8, meaning program-buffer entries (power of two, at least 2).
REQ-002 Parameter DATA_W, default 32, meaning instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 load_we  input  1  program-buffer write enable.
REQ-006 load_addr  input  log2(DEPTH)  program-buffer write address.
REQ-007 load_data  input  DATA_W  instruction word to write.
REQ-008 start  input  1  single-cycle pulse that begins a run.
REQ-009 step_mode  input  1  when 1, pause after every issued instruction.
REQ-010 step  input  1  single-cycle pulse that resumes from PAUSE.
REQ-011 abort  input  1  terminates a run.
REQ-012 inst_ready  input  1  datapath accepts inst_ex this cycle.
REQ-013 inst_ex  output  DATA_W  instruction presented to the datapath.
REQ-014 inst_valid  output  1  inst_ex is valid.
REQ-015 pc  output  log2(DEPTH)  current buffer index.
REQ-016 issue_count  output  log2(DEPTH)+1  transfers completed in the current run.
REQ-017 busy  output  1  high in ISSUE or PAUSE.
REQ-018 done  output  1  one-cycle pulse at run end.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, PAUSE and DONE.
REQ-020 Buffer writes SHALL occur only when load_we=1 in IDLE; load_we in any other state SHALL be ignored.
REQ-021 IDLE with start=1 SHALL go to ISSUE next cycle with pc=0 and issue_count=0; a same-cycle buffer write SHALL be visible to the first issue.
REQ-022 In ISSUE with buf[pc]!=0, inst_valid SHALL be 1 and inst_ex SHALL equal buf[pc] combinationally.
REQ-023 In all other states and cases, inst_ex SHALL be 0 and inst_valid SHALL be 0.
REQ-024 A transfer SHALL occur when inst_valid=1 and inst_ready=1 on the same edge; issue_count SHALL then increment.
REQ-025 While inst_valid=1 and inst_ready=0, inst_ex and pc SHALL hold stable, with no timeout.
REQ-026 On a transfer with pc=DEPTH-1, the FSM SHALL go to DONE; pc SHALL NOT wrap.
REQ-027 On any other transfer, pc SHALL increment, and the FSM SHALL go to PAUSE if step_mode=1, else stay in ISSUE.
REQ-028 A halt word (buf[pc]==0) in ISSUE SHALL never be issued, and the FSM SHALL go to DONE next cycle.
REQ-029 In PAUSE, step=1 SHALL return the FSM to ISSUE; other inputs SHALL be ignored except abort.
REQ-030 abort=1 in ISSUE or PAUSE SHALL go to IDLE next cycle with no done pulse.
REQ-031 If abort coincides with a transfer, the transfer SHALL be counted, and abort SHALL determine the next state.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 DONE SHALL last exactly one cycle with done=1, then go to IDLE; pc and issue_count SHALL hold until the next start.
REQ-034 start outside IDLE SHALL be ignored.
REQ-035 step outside PAUSE SHALL be ignored.
REQ-036 busy SHALL be 1 exactly in ISSUE and PAUSE.

Reset
REQ-037 rst=1 SHALL immediately force IDLE and clear all buffer entries, pc and issue_count to 0.
REQ-038 rst=1 SHALL immediately force inst_ex=0, inst_valid=0, busy=0 and done=0, independent of clk.
REQ-039 rst asserted mid-run SHALL discard the run and produce no done pulse.
REQ-040 After rst deasserts, the first load or start SHALL be accepted on the next rising edge.

Verification
REQ-041 Load buf[0]=0x54010005, buf[1]=0x50060002, buf[2]=0; start; inst_ready=1 -> 0x54010005 then 0x50060002 issued on consecutive cycles, no issue of buf[2], done pulses once, issue_count=2.
REQ-042 Same program, inst_ready=0 for 3 cycles after start -> inst_ex stays 0x54010005 with pc=0 for 3 cycles, then issues on the first ready cycle.
REQ-043 Same program, step_mode=1 -> after the first transfer, PAUSE with inst_valid=0; a step pulse issues 0x50060002; extra step pulses while in ISSUE change nothing.
REQ-044 All 8 entries nonzero, inst_ready=1 -> 8 transfers, pc stops at 7, issue_count=8, done pulses, no wrap to entry 0.
REQ-045 Abort coincident with the second transfer -> issue_count=2, IDLE next cycle, no done; a load_we during ISSUE leaves the buffer unchanged.
REQ-046 Assert rst asynchronously mid-run while inst_valid=1 -> inst_valid=0 before the next edge, the buffer reads all zero, and a following start goes straight to DONE.
